// File: rtl/fb_scanout.sv
// Frame buffer scan-out: walks a rectangular window in raster order, reads the RAM
// and streams {r,g,b} pixels with x/y through a small FIFO that absorbs read latency.
module fb_scanout #(
    parameter int RD_LAT = 1,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_3,
    output logic        ack_3,
    output logic        busy,
    input  logic [15:0] win_min_xy,
    input  logic [15:0] win_max_xy,
    output logic [15:0] raddr,
    output logic        re,
    input  logic [7:0]  rdata,
    input  logic [7:0]  gdata,
    input  logic [7:0]  bdata,
    output logic [23:0] pix_rgb,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t      state, state_nx;
    logic [7:0]  min_x, min_y, max_x, max_y;
    logic [7:0]  cx, cy;

    // Per-read tag {last, y, x} riding alongside the RAM latency
    logic [RD_LAT-1:0] pipe_v;
    logic [16:0]       pipe_d [RD_LAT];

    // FIFO entry: {last, y, x, rgb}
    logic [40:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_count;
    logic [40:0]   head;

    logic start, empty_win, last_rd, fifo_wr, fifo_rd;
    int   inflight;

    assign start     = (state == IDLE) && req_3;
    assign empty_win = (win_min_xy[7:0] > win_max_xy[7:0]) || (win_min_xy[15:8] > win_max_xy[15:8]);
    assign last_rd   = (cx == max_x) && (cy == max_y);
    assign fifo_wr   = pipe_v[RD_LAT-1];
    assign pix_valid = (fifo_count != '0);
    assign fifo_rd   = pix_valid && pix_ready;
    assign head      = fifo_mem[rd_ptr];

    assign pix_rgb  = pix_valid ? head[23:0]  : '0;
    assign pix_x    = pix_valid ? head[31:24] : '0;
    assign pix_y    = pix_valid ? head[39:32] : '0;
    assign pix_last = pix_valid && head[40];
    assign ack_3    = (state == DONE);
    assign busy     = (state != IDLE);
    assign raddr    = re ? {cy, cx} : '0;

    always_comb inflight = $countones(pipe_v);

    // A slot freed by this cycle's pop is reusable, which keeps 1 pixel/cycle at RD_LAT+1 depth
    always_comb begin
        re = 1'b0;
        if (state == READ && (int'(fifo_count) + inflight - int'(fifo_rd)) < DEPTH)
            re = 1'b1;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
        state_nx = state;
        case (state)
            IDLE:    if (req_3) state_nx = empty_win ? DONE : READ;
            READ:    if (re && last_rd) state_nx = DRAIN;
            DRAIN:   if (fifo_rd && head[40]) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            min_x  <= '0;
            min_y  <= '0;
            max_x  <= '0;
            max_y  <= '0;
            cx     <= '0;
            cy     <= '0;
            pipe_v <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                {min_y, min_x} <= win_min_xy;
                {max_y, max_x} <= win_max_xy;
                {cy, cx}       <= win_min_xy;
            end else if (re) begin
                if (cx == max_x) begin
                    cx <= min_x;
                    cy <= cy + 8'd1;
                end else begin
                    cx <= cx + 8'd1;
                end
            end
            pipe_v[0] <= re;
            for (int i = 1; i < RD_LAT; i++) pipe_v[i] <= pipe_v[i-1];
        end
    end

    // NOTE: payload storage is not reset; only the valid bits and pointers/count need a known state.
    always_ff @(posedge clk) begin
        pipe_d[0] <= {last_rd, cy, cx};
        for (int i = 1; i < RD_LAT; i++) pipe_d[i] <= pipe_d[i-1];
        if (fifo_wr) fifo_mem[wr_ptr] <= {pipe_d[RD_LAT-1], rdata, gdata, bdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            if (fifo_wr && !fifo_rd)      fifo_count <= fifo_count + 1'b1;
            else if (!fifo_rd && !fifo_wr) fifo_count <= fifo_count;
            else if (fifo_rd && !fifo_wr) fifo_count <= fifo_count - 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_wr && !fifo_rd && fifo_count == (AW+1)'(DEPTH)));

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: one RD_LAT=1 and one RD_LAT=3 instance, each fed by
// a behavioural RAM whose contents are an address-derived pattern plus a drawn white shape.
module tb_fb_scanout;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] mem [65536];

    // Instance A: RD_LAT=1
    logic        a_req = 1'b0, a_ack, a_busy, a_re, a_valid, a_ready = 1'b0, a_last;
    logic [15:0] a_min = '0, a_max = '0, a_raddr;
    logic [7:0]  a_r, a_g, a_b, a_x, a_y;
    logic [23:0] a_rgb, a_q;

    // Instance B: RD_LAT=3
    logic        b_req = 1'b0, b_ack, b_busy, b_re, b_valid, b_ready = 1'b0, b_last;
    logic [15:0] b_min = '0, b_max = '0, b_raddr;
    logic [7:0]  b_r, b_g, b_b, b_x, b_y;
    logic [23:0] b_rgb, b_q1, b_q2, b_q3;

    fb_scanout #(.RD_LAT(1), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .req_3(a_req), .ack_3(a_ack), .busy(a_busy),
        .win_min_xy(a_min), .win_max_xy(a_max), .raddr(a_raddr), .re(a_re),
        .rdata(a_r), .gdata(a_g), .bdata(a_b), .pix_rgb(a_rgb), .pix_x(a_x), .pix_y(a_y),
        .pix_valid(a_valid), .pix_ready(a_ready), .pix_last(a_last));

    fb_scanout #(.RD_LAT(3), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .req_3(b_req), .ack_3(b_ack), .busy(b_busy),
        .win_min_xy(b_min), .win_max_xy(b_max), .raddr(b_raddr), .re(b_re),
        .rdata(b_r), .gdata(b_g), .bdata(b_b), .pix_rgb(b_rgb), .pix_x(b_x), .pix_y(b_y),
        .pix_valid(b_valid), .pix_ready(b_ready), .pix_last(b_last));

    always @(posedge clk) begin
        a_q  <= mem[a_raddr];
        b_q1 <= mem[b_raddr];
        b_q2 <= b_q1;
        b_q3 <= b_q2;
    end
    assign {a_r, a_g, a_b} = a_q;
    assign {b_r, b_g, b_b} = b_q3;

    task automatic init_mem;
        for (int i = 0; i < 65536; i++) begin
            logic [7:0] x, y;
            x = i[7:0];
            y = i[15:8];
            mem[i] = {x ^ 8'hA5, y, x + y};
            if (y >= 8'h30 && y <= 8'hA0 && x >= 8'h25 && x <= 8'h90 && (x - 8'h25) <= (y - 8'h30))
                mem[i] = 24'hFFFFFF;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_ack, a_busy, a_re, a_raddr, a_valid, a_last, a_rgb, a_x, a_y} !== '0) begin
            errors++;
            $display("FAIL reset_a: outputs=%h required all zero",
                     {a_ack, a_busy, a_re, a_raddr, a_valid, a_last, a_rgb, a_x, a_y});
        end
        checks++;
        if ({b_ack, b_busy, b_re, b_raddr, b_valid, b_last, b_rgb, b_x, b_y} !== '0) begin
            errors++;
            $display("FAIL reset_b: outputs=%h required all zero",
                     {b_ack, b_busy, b_re, b_raddr, b_valid, b_last, b_rgb, b_x, b_y});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b required 0", a_busy);
        end
    endtask

    // 2x2 window, cycle-exact: re 1-4, pix_valid 3-6, last 6, ack 7, busy low 8
    task automatic test_basic_window;
        logic [20:0] got, exp;
        logic [15:0] ea;
        logic [7:0]  px, py;
        a_min = 16'h0000; a_max = 16'h0101; a_ready = 1'b1;
        @(negedge clk); a_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk); a_req = 1'b0; #1;
            ea = (c <= 4) ? {8'((c-1)/2), 8'((c-1)%2)} : 16'h0000;
            exp = {(c <= 4), ea, (c >= 3 && c <= 6), (c == 6), (c == 7), (c <= 7)};
            got = {a_re, a_raddr, a_valid, a_last, a_ack, a_busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_ctrl c%0d: {re,raddr,valid,last,ack,busy}=%h required %h", c, got, exp);
            end
            if (c >= 3 && c <= 6) begin
                px = 8'((c-3)%2);
                py = 8'((c-3)/2);
                checks++;
                if ({a_rgb, a_y, a_x} !== {mem[{py, px}], py, px}) begin
                    errors++;
                    $display("FAIL basic_pix c%0d: rgb/y/x=%h required %h", c,
                             {a_rgb, a_y, a_x}, {mem[{py, px}], py, px});
                end
            end
        end
    endtask

    // Runs one scan on instance A; mode 0: ready always 1, mode 1: ready 1,0,0 repeating
    task automatic scan_a(input logic [15:0] mn, input logic [15:0] mx, input int mode,
                          input string name, input int budget);
        int total, npix, issued, lasts, bad_addr, bad_pix, bad_occ, bad_stab, occ;
        logic ack_seen, stall_prev, xfer;
        logic [7:0] rx, ry, ex, ey;
        logic [40:0] snap;
        total = (int'(mx[7:0]) - int'(mn[7:0]) + 1) * (int'(mx[15:8]) - int'(mn[15:8]) + 1);
        npix = 0; issued = 0; lasts = 0;
        bad_addr = 0; bad_pix = 0; bad_occ = 0; bad_stab = 0;
        ack_seen = 1'b0; stall_prev = 1'b0; snap = '0;
        {ry, rx} = mn; {ey, ex} = mn;
        a_min = mn; a_max = mx; a_ready = 1'b1;
        @(negedge clk); a_req = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk); a_req = 1'b0;
            a_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 1);
            #1;
            xfer = a_valid && a_ready;
            if (stall_prev && {a_valid, a_last, a_y, a_x, a_rgb} !== {1'b1, snap}) bad_stab++;
            if (a_re) begin
                if (a_raddr !== {ry, rx}) bad_addr++;
                if (rx == mx[7:0]) begin rx = mn[7:0]; ry++; end else rx++;
                issued++;
            end
            if (xfer) begin
                if ({a_rgb, a_y, a_x} !== {mem[{ey, ex}], ey, ex}) bad_pix++;
                if (a_last !== (npix == total - 1)) bad_pix++;
                if (a_last) lasts++;
                if (ex == mx[7:0]) begin ex = mn[7:0]; ey++; end else ex++;
                npix++;
            end
            occ = issued - npix;
            if (occ > 4) bad_occ++;
            stall_prev = a_valid && !a_ready;
            snap = {a_last, a_y, a_x, a_rgb};
            if (a_ack) begin ack_seen = 1'b1; break; end
        end
        checks++;
        if (!ack_seen) begin errors++; $display("FAIL %s_ack: ack_3 not seen in %0d cycles", name, budget); end
        checks++;
        if (npix != total) begin errors++; $display("FAIL %s_count: transfers=%0d required %0d", name, npix, total); end
        checks++;
        if (issued != total) begin errors++; $display("FAIL %s_reads: reads=%0d required %0d", name, issued, total); end
        checks++;
        if (lasts != 1) begin errors++; $display("FAIL %s_last: pix_last transfers=%0d required 1", name, lasts); end
        checks++;
        if (bad_addr != 0) begin errors++; $display("FAIL %s_raddr: out-of-order reads=%0d required 0", name, bad_addr); end
        checks++;
        if (bad_pix != 0) begin errors++; $display("FAIL %s_pixel: bad pixels=%0d required 0", name, bad_pix); end
        checks++;
        if (bad_occ != 0) begin errors++; $display("FAIL %s_occupancy: cycles over depth=%0d required 0", name, bad_occ); end
        checks++;
        if (bad_stab != 0) begin errors++; $display("FAIL %s_stable: unstable stalled cycles=%0d required 0", name, bad_stab); end
        @(negedge clk); #1;
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL %s_idle: busy=%b required 0", name, a_busy); end
    endtask

    task automatic test_full_frame;
        scan_a(16'h0000, 16'hFFFF, 0, "full", 66000);
    endtask

    task automatic test_backpressure;
        scan_a(16'h1010, 16'h1013, 1, "bp", 100);
    endtask

    task automatic test_empty_window;
        logic stray;
        stray = 1'b0;
        a_min = 16'h0205; a_max = 16'h0204; a_ready = 1'b1;
        @(negedge clk); a_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); a_req = 1'b0; #1;
            if (a_re || a_valid) stray = 1'b1;
            if (c <= 2) begin
                checks++;
                if ({a_ack, a_busy} !== ((c == 1) ? 2'b11 : 2'b00)) begin
                    errors++;
                    $display("FAIL empty_ack c%0d: {ack,busy}=%b required %b", c, {a_ack, a_busy},
                             (c == 1) ? 2'b11 : 2'b00);
                end
            end
        end
        checks++;
        if (stray) begin errors++; $display("FAIL empty_noread: re/pix_valid=1 required 0"); end
    endtask

    task automatic test_midframe_reset;
        logic hit;
        hit = 1'b0;
        a_min = 16'h0000; a_max = 16'h0007; a_ready = 1'b1;
        @(negedge clk); a_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk); a_req = 1'b0; #1;
            if (a_valid && a_x == 8'd2) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL mrst_reach: pixel 3 never presented"); end
        rst = 1'b1;
        #1;
        checks++;
        if ({a_ack, a_busy, a_re, a_raddr, a_valid, a_last, a_rgb, a_x, a_y} !== '0) begin
            errors++;
            $display("FAIL mrst_zero: outputs=%h required all zero",
                     {a_ack, a_busy, a_re, a_raddr, a_valid, a_last, a_rgb, a_x, a_y});
        end
        @(negedge clk); rst = 1'b0;
        scan_a(16'h0000, 16'h0007, 0, "rescan", 40);
    endtask

    // RD_LAT=3: four reads stall behind a blocked consumer, then one pixel per cycle
    task automatic test_rdlat3_stall;
        int issued, npix, max_occ, stalled_issued, first_cyc, last_cyc, bad;
        logic ack_seen;
        logic [7:0] ex;
        issued = 0; npix = 0; max_occ = 0; stalled_issued = -1;
        first_cyc = -1; last_cyc = -1; bad = 0; ack_seen = 1'b0; ex = 8'h00;
        b_min = 16'h0000; b_max = 16'h000F; b_ready = 1'b0;
        @(negedge clk); b_req = 1'b1;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            @(negedge clk); b_req = 1'b0; b_ready = (cyc > 20); #1;
            if (b_re) begin
                if (b_raddr !== {8'h00, 8'(issued)}) bad++;
                issued++;
            end
            if (b_valid && b_ready) begin
                if ({b_rgb, b_y, b_x} !== {mem[{8'h00, ex}], 8'h00, ex}) bad++;
                if (b_last !== (ex == 8'h0F)) bad++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                ex++;
                npix++;
            end
            if (issued - npix > max_occ) max_occ = issued - npix;
            if (cyc == 20) stalled_issued = issued;
            if (b_ack) begin ack_seen = 1'b1; break; end
        end
        checks++;
        if (stalled_issued != 4) begin errors++; $display("FAIL lat3_stall: reads while blocked=%0d required 4", stalled_issued); end
        checks++;
        if (max_occ > 4) begin errors++; $display("FAIL lat3_occ: outstanding+buffered=%0d required <=4", max_occ); end
        checks++;
        if (first_cyc != 21) begin errors++; $display("FAIL lat3_first: first transfer cycle=%0d required 21", first_cyc); end
        checks++;
        if (last_cyc - first_cyc != 15) begin errors++; $display("FAIL lat3_rate: span=%0d required 15", last_cyc - first_cyc); end
        checks++;
        if (npix != 16 || bad != 0) begin errors++; $display("FAIL lat3_data: pixels=%0d bad=%0d required 16/0", npix, bad); end
        checks++;
        if (!ack_seen) begin errors++; $display("FAIL lat3_ack: ack_3 not seen"); end
    endtask

    initial begin
        init_mem();
        test_reset();
        test_basic_window();
        test_empty_window();
        test_backpressure();
        test_midframe_reset();
        test_rdlat3_stall();
        test_full_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
